// File: rtl/reg_file_8x16_pkg.sv
// Shared sizing constants for the 16-bit RISC register file, decoder and datapath.
package reg_file_8x16_pkg;

  localparam int unsigned RF_DATA_W   = 16;
  localparam int unsigned RF_ADDR_W   = 3;
  localparam int unsigned RF_NUM_REGS = 1 << RF_ADDR_W;

endpackage : reg_file_8x16_pkg

// File: rtl/reg_file_8x16.sv
// Eight-entry general-purpose register file: two registered read ports, one write port,
// all activity gated by the stage enable. Reads return pre-write contents (no bypass).
module reg_file_8x16
  import reg_file_8x16_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_EN,
  input  logic              I_WE,
  input  logic [ADDR_W-1:0] I_SELA,
  input  logic [ADDR_W-1:0] I_SELB,
  input  logic [ADDR_W-1:0] I_SELD,
  input  logic [DATA_W-1:0] I_DATAD,
  output logic [DATA_W-1:0] O_DATAA,
  output logic [DATA_W-1:0] O_DATAB
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = I_EN && I_WE && (I_SELD == ADDR_W'(i));
    end
  end

  // Read muxes sample the array before this edge's write lands, giving old-data semantics.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_DATAA <= '0;
      O_DATAB <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (I_EN) begin
        O_DATAA <= regs[I_SELA];
        O_DATAB <= regs[I_SELB];
      end
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= I_DATAD;
        end
      end
    end
  end

endmodule : reg_file_8x16

// File: tb/tb_reg_file_8x16.sv
// Directed-vector bench for reg_file_8x16 with hand-computed expected read data.
module tb_reg_file_8x16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        we;
  logic [2:0]  sela;
  logic [2:0]  selb;
  logic [2:0]  seld;
  logic [15:0] datad;
  logic [15:0] dataa;
  logic [15:0] datab;

  int unsigned checks;
  int unsigned failures;

  reg_file_8x16 #(.DATA_W(16), .ADDR_W(3)) dut (
    .I_CLK   (clk),
    .I_RST_N (rst_n),
    .I_EN    (en),
    .I_WE    (we),
    .I_SELA  (sela),
    .I_SELB  (selb),
    .I_SELD  (seld),
    .I_DATAD (datad),
    .O_DATAA (dataa),
    .O_DATAB (datab)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs set before this apply at that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic [15:0] wd);
    en = e; we = w; sela = a; selb = b; seld = d; datad = wd;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'(i), 3'(7 - i), 3'd0, 16'h0000);
      step();
      check({tag, "_a"}, dataa, 16'h0000);
      check({tag, "_b"}, datab, 16'h0000);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000);
    #2;
    check("rst_async_a", dataa, 16'h0000);
    check("rst_async_b", datab, 16'h0000);
    #1 rst_n = 1'b1;
    read_all_zero("rst_regs");

    // Basic write of r0, read on both ports
    drive(1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 16'hFFFF);
    step();
    check("r0_old_a", dataa, 16'h0000);
    drive(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 16'hFFFF);
    step();
    check("r0_new_a", dataa, 16'hFFFF);
    check("r0_new_b", datab, 16'hFFFF);

    // WE gating on r2
    drive(1'b1, 1'b0, 3'd2, 3'd2, 3'd2, 16'h2222);
    step();
    check("we0_r2_1", dataa, 16'h0000);
    step();
    check("we0_r2_2", dataa, 16'h0000);
    drive(1'b1, 1'b1, 3'd2, 3'd2, 3'd2, 16'h2222);
    step();
    check("we1_r2_old", dataa, 16'h0000);
    drive(1'b1, 1'b1, 3'd2, 3'd2, 3'd2, 16'h3333);
    step();
    check("we1_r2_2222", dataa, 16'h2222);
    drive(1'b1, 1'b0, 3'd2, 3'd2, 3'd2, 16'h3333);
    step();
    check("we1_r2_3333", dataa, 16'h3333);

    // No spurious write to r1, then write r4
    drive(1'b1, 1'b0, 3'd1, 3'd1, 3'd1, 16'hFEED);
    step();
    step();
    check("nowr_r1", dataa, 16'h0000);
    drive(1'b1, 1'b1, 3'd1, 3'd1, 3'd4, 16'h4444);
    step();
    drive(1'b1, 1'b0, 3'd2, 3'd4, 3'd4, 16'h4444);
    step();
    check("r2_a", dataa, 16'h3333);
    check("r4_b", datab, 16'h4444);

    // Enable low: writes, reads and outputs all frozen
    drive(1'b0, 1'b1, 3'd0, 3'd1, 3'd2, 16'hDEAD);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_a", dataa, 16'h3333);
      check("hold_b", datab, 16'h4444);
    end
    drive(1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 16'h0000);
    step();
    check("reen_r2", dataa, 16'h3333);
    check("reen_r0", datab, 16'hFFFF);

    // Read-during-write to r3 returns old data
    drive(1'b1, 1'b1, 3'd3, 3'd3, 3'd3, 16'hA5A5);
    step();
    check("rdw_old_a", dataa, 16'h0000);
    check("rdw_old_b", datab, 16'h0000);
    drive(1'b1, 1'b0, 3'd3, 3'd3, 3'd3, 16'hA5A5);
    step();
    check("rdw_new_a", dataa, 16'hA5A5);

    // Held WE rewrites r5 idempotently; top register r7
    drive(1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 16'h5555);
    step();
    step();
    check("hold_we_r5", dataa, 16'h5555);
    drive(1'b1, 1'b1, 3'd5, 3'd5, 3'd7, 16'h7777);
    step();
    check("r5_again", datab, 16'h5555);
    drive(1'b1, 1'b0, 3'd7, 3'd1, 3'd0, 16'h0000);
    step();
    check("r7_a", dataa, 16'h7777);
    check("r1_b", datab, 16'h0000);

    // Asynchronous reset mid-cycle with non-zero outputs
    drive(1'b1, 1'b0, 3'd7, 3'd0, 3'd0, 16'h0000);
    step();
    check("pre_rst_a", dataa, 16'h7777);
    check("pre_rst_b", datab, 16'hFFFF);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_a", dataa, 16'h0000);
    check("rst_mid_b", datab, 16'h0000);
    #1 rst_n = 1'b1;
    read_all_zero("rst2_regs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file_8x16
